uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Queues 16-bit words issued by the CPU control FSM during its TRANSMIT state.
- Serialises each word as two 8N1 UART frames on a single tx line.
- Decouples single-cycle transmit instructions from multi-thousand-cycle serial timing using a small word FIFO, baud timer and frame sequencer.
- Reports back-pressure and overflow status to the core.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, word FIFO entries; must be a power of 2, minimum 2.
- MSB_FIRST, 1, 1 = high byte of each word sent first; 0 = low byte first.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_req  input  1  enqueue strobe, sampled every rising edge (driven by transmit_enable).
- tx_data  input  16  word to enqueue, valid with tx_req.
- ovf_clr  input  1  clears sticky overflow flag.
- tx  output  1  serial line, idle high.
- busy  output  1  high while FIFO is non-empty or a frame is in progress.
- fifo_full  output  1  high when count == FIFO_DEPTH.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of queued words.
- overflow  output  1  sticky; set when a tx_req is dropped.

Behaviour:
- Reset (rst low, asynchronous, immediate):
  - tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0.
  - FSM returns to IDLE; FIFO pointers, baud counter, bit counter and byte select are cleared.
  - Reset mid-frame aborts the frame with no completion; tx is high while rst is low.
- Enqueue:
  - At a rising edge with tx_req=1 and the pre-edge count < FIFO_DEPTH, tx_data is written at the tail.
  - If the pre-edge count == FIFO_DEPTH, the word is dropped and overflow=1 after that edge. This applies even when a pop occurs on the same edge.
- Pop and push on the same edge: count is unchanged and both operations complete.
- overflow:
  - Cleared by ovf_clr=1 at an edge.
  - Set has priority over clear on the same edge.
- All outputs are registered except busy, fifo_full and fifo_count, which decode from registered state and count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count > 0, pop the head word into the hold register, select the first byte per MSB_FIRST, tx<=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA, driving bit 0.
  - DATA: 8 bits, LSB first within each byte, each held CLKS_PER_BIT cycles. A 3-bit counter tracks the bit; after bit 7 go to STOP with tx<=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If the first byte is done, select the second byte, tx<=0, go to START with no gap.
    - Otherwise go to IDLE.
- Timing:
  - The baud counter counts 0..CLKS_PER_BIT-1 and resets on every state entry.
  - Word latency: tx falls on the first edge after the write edge when the FSM is in IDLE.
  - Frame: one word = 20*CLKS_PER_BIT cycles of frame time.
  - Consecutive words have exactly one idle clock (tx high, in IDLE) between the second stop bit and the next start bit.
- busy = (state != IDLE) || (count != 0). busy falls on the edge entering IDLE with an empty FIFO.
- Pointers wrap modulo FIFO_DEPTH. Count saturates logically via the full check and never exceeds FIFO_DEPTH.
- tx_data is captured only at enqueue; later changes have no effect.

Test Plan:
- Single word, CLKS_PER_BIT=4, MSB_FIRST=1, tx_req for one cycle with 0xA55A:
  - tx = 0, 1,0,1,0,0,1,0,1, 1, then 0, 0,1,0,1,1,0,1,0, 1, each bit 4 clocks.
  - tx falls one edge after the request.
  - busy stays high for 80 clocks after the fall, then drops.
- Fill, CLKS_PER_BIT=4, FIFO_DEPTH=4, six consecutive tx_req with 0x0001..0x0006:
  - The first five are accepted; 0x0006 is dropped.
  - fifo_full=1, fifo_count=4, overflow=1.
  - The line emits words 0x0001..0x0005 in order, with a 1-clock idle gap between words.
- Overflow priority: ovf_clr=1 on the same edge as a dropped tx_req leaves overflow=1; ovf_clr alone on the next edge clears it to 0.
- Reset during DATA bit 3 of the first byte with 2 words queued:
  - tx=1, count=0 and busy=0 immediately.
  - After rst deasserts, the line stays idle with no residual frame.
- Byte order, MSB_FIRST=0, word 0x1280: the first frame carries 0x80 (bits 0,0,0,0,0,0,0,1) and the second carries 0x12.
- Simultaneous push/pop: while the FSM is in IDLE with count=4, a tx_req on the pop edge is dropped, overflow=1 and count=3 afterwards.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: queues 16-bit words from the core and sends each one as
// two back-to-back 8N1 UART frames on a single serial line.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   tx_req     enqueue strobe, one word per cycle
//   tx_data    word to enqueue, valid with tx_req
//   ovf_clr    clears the sticky overflow flag
//   tx         serial line, idle high (registered)
//   busy       FIFO non-empty or frame in progress (decoded from state/count)
//   fifo_full  count == FIFO_DEPTH (decoded from count)
//   fifo_count number of queued words
//   overflow   sticky, set when a tx_req is dropped (registered)
module uart_tx_scheduler #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_req,
  input  logic [15:0]                   tx_data,
  input  logic                          ovf_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic            second_q, second_d;
  logic [15:0]     hold_q, hold_d;
  logic            tx_q, tx_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic            full_c;
  logic            push_c;
  logic            drop_c;
  logic            pop_c;
  logic            baud_done_c;
  logic [7:0]      cur_byte_c;
  logic [2:0]      bit_nxt_c;

  // FIFO control; full check uses the pre-edge count so a same-edge pop never frees a slot
  assign full_c      = (count_q == CW'(FIFO_DEPTH));
  assign push_c      = tx_req && !full_c;
  assign drop_c      = tx_req && full_c;
  assign pop_c       = (state_q == IDLE) && (count_q != '0);
  assign baud_done_c = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign bit_nxt_c   = bit_cnt_q + 3'd1;

  // High byte is on the line when exactly one of (second byte, MSB_FIRST) holds
  assign cur_byte_c  = (second_q ^ MSB_FIRST) ? hold_q[15:8] : hold_q[7:0];

  // Pointer, count and sticky overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (drop_c) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // Frame sequencer next-state; baud counter restarts on every state entry
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    second_d  = second_q;
    hold_d    = hold_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop_c) begin
          hold_d   = mem_q[rd_ptr_q];
          second_d = 1'b0;
          baud_d   = '0;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_done_c) begin
          baud_d    = '0;
          bit_cnt_d = '0;
          tx_d      = cur_byte_c[0];
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_done_c) begin
          baud_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_nxt_c;
            tx_d      = cur_byte_c[bit_nxt_c];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_done_c) begin
          baud_d = '0;
          if (!second_q) begin
            // Second byte follows the first stop bit with no gap
            second_d = 1'b1;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      baud_q     <= '0;
      bit_cnt_q  <= '0;
      second_q   <= 1'b0;
      hold_q     <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      second_q   <= second_d;
      hold_q     <= hold_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  // Word storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx         = tx_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_full  = full_c;
  assign fifo_count = count_q;

endmodule
